// File: rtl/uart_pkg.sv
// uart_pkg: link-wide UART constants and receiver state encoding shared by rx/tx
package uart_pkg;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_PARITY_ENABLED = 1;
   localparam int DEF_OVERSAMPLE     = 16;
   // 0 = even parity: the parity bit makes the total count of ones even
   localparam logic PARITY_ODD = 1'b0;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input, reset to RESET_VAL
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   always_ff @(posedge clk)
      if (reset) {o_q, r_meta} <= {RESET_VAL, RESET_VAL};
      else       {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/rx_uart.sv
// rx_uart: oversampling serial receiver (start, LSB-first data, optional parity, stop).
// Define RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around mid-bit.
module rx_uart
   import uart_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PARITY_ENABLED   = DEF_PARITY_ENABLED,
   parameter int OVERSAMPLE       = DEF_OVERSAMPLE
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        sample_tick,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] o_data,
   output logic                        o_valid,
   output logic                        o_parity_err,
   output logic                        o_framing_err,
   output logic                        o_busy
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(INPUT_DATA_WIDTH + 1);
`ifdef RX_MAJORITY_VOTE_EN
   localparam int SKEW = 2;
`else
   localparam int SKEW = 0;
`endif
   localparam logic [CW-1:0] START_END = CW'(OVERSAMPLE / 2 - 1 + SKEW);
   localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(INPUT_DATA_WIDTH - 1);

   rx_state_t                 r_state, w_state_nx;
   logic [CW-1:0]             r_tick_cnt;
   logic [BW-1:0]             r_bit_cnt;
   logic [INPUT_DATA_WIDTH-1:0] r_shift;
   logic                      r_par;
   logic                      w_sin, w_bit, w_tick_end, w_sample;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk  (clk),
      .reset(reset),
      .i_d  (serial_in),
      .o_q  (w_sin)
   );

`ifdef RX_MAJORITY_VOTE_EN
   // Two previous tick samples; with the current one they form the vote window
   logic [1:0] r_hist;
   always_ff @(posedge clk)
      if (reset)            r_hist <= 2'b11;
      else if (sample_tick) r_hist <= {r_hist[0], w_sin};
   assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_sin) | (r_hist[0] & w_sin);
`else
   assign w_bit = w_sin;
`endif

   assign w_tick_end = (r_state == START) ? (r_tick_cnt == START_END) : (r_tick_cnt == BIT_END);
   assign w_sample   = sample_tick & w_tick_end;

   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nx;

   always_comb begin
      w_state_nx = r_state;
      if (sample_tick)
         case (r_state)
            IDLE:      w_state_nx = w_sin ? IDLE : START;
            START:     if (w_tick_end) w_state_nx = w_bit ? IDLE : DATA;
            DATA:      if (w_tick_end && r_bit_cnt == LAST_BIT)
                          w_state_nx = (PARITY_ENABLED != 0) ? PARITY : STOP;
            PARITY:    if (w_tick_end) w_state_nx = STOP;
            STOP:      if (w_tick_end) w_state_nx = w_bit ? IDLE : WAIT_IDLE;
            WAIT_IDLE: w_state_nx = w_sin ? IDLE : WAIT_IDLE;
            default:   w_state_nx = IDLE;
         endcase
   end

   always_comb o_busy = (r_state != IDLE);

   always_ff @(posedge clk)
      if (reset) begin
         r_tick_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_par         <= 1'b0;
         o_data        <= '0;
         o_valid       <= 1'b0;
         o_parity_err  <= 1'b0;
         o_framing_err <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (sample_tick) begin
            r_tick_cnt <= (r_state == IDLE || r_state == WAIT_IDLE || w_tick_end) ? '0 : r_tick_cnt + 1'b1;
            if (r_state == DATA && w_tick_end) begin
               r_shift   <= {w_bit, r_shift[INPUT_DATA_WIDTH-1:1]};
               r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
            end
            if (r_state == PARITY && w_tick_end) r_par <= w_bit;
         end
         if (r_state == STOP && w_sample) begin
            o_valid       <= 1'b1;
            o_data        <= r_shift;
            o_parity_err  <= (PARITY_ENABLED != 0) & (r_par ^ (^r_shift) ^ PARITY_ODD);
            o_framing_err <= ~w_bit;
         end
      end
endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: directed vector table plus framing/glitch/reset/loopback sequences for rx_uart
module tb_rx_uart;
   logic       clk = 1'b0;
   logic       reset, sample_tick, serial_in;
   logic [7:0] o_data;
   logic       o_valid, o_parity_err, o_framing_err, o_busy;
   int         checks = 0, errors = 0;
   logic       prev_valid = 1'b0;

   typedef struct packed {logic [7:0] d; logic pe; logic fe;} rec_t;
   rec_t q[$];

   typedef struct {logic [7:0] d; logic p; logic s; logic pe; logic fe;} vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   rx_uart #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .OVERSAMPLE(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .serial_in    (serial_in),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_parity_err (o_parity_err),
      .o_framing_err(o_framing_err),
      .o_busy       (o_busy)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   always @(negedge clk)
      if (reset) prev_valid = 1'b0;
      else begin
         if (o_valid) begin
            chk("valid_one_cycle", 32'(prev_valid), 32'(0));
            q.push_back('{o_data, o_parity_err, o_framing_err});
         end
         prev_valid = o_valid;
      end

   task automatic bitp(input logic v, input int n);
      serial_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic p, input logic s);
      bitp(1'b0, 16);
      for (int i = 0; i < 8; i++) bitp(d[i], 16);
      bitp(p, 16);
      bitp(s, 16);
   endtask

   task automatic expect_rx(input string n, input logic [7:0] d, input logic pe, input logic fe);
      rec_t r;
      int t = 0;
      while (q.size() == 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (q.size() == 0) chk({n, "_timeout"}, 32'(0), 32'(1));
      else begin
         r = q.pop_front();
         chk({n, "_data"}, 32'(r.d), 32'(d));
         chk({n, "_perr"}, 32'(r.pe), 32'(pe));
         chk({n, "_ferr"}, 32'(r.fe), 32'(fe));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0};
      reset = 1'b1;
      sample_tick = 1'b1;
      serial_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_data", 32'(o_data), 32'(0));
      chk("rst_valid", 32'(o_valid), 32'(0));
      chk("rst_perr", 32'(o_parity_err), 32'(0));
      chk("rst_ferr", 32'(o_framing_err), 32'(0));
      chk("rst_busy", 32'(o_busy), 32'(0));
      reset = 1'b0;
      bitp(1'b1, 20);

      foreach (vecs[i]) begin
         send(vecs[i].d, vecs[i].p, vecs[i].s);
         bitp(1'b1, 4);
         expect_rx($sformatf("vec%0d", i), vecs[i].d, vecs[i].pe, vecs[i].fe);
         chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(0));
      end

      // break after a bad stop bit: one frame only, busy until the line recovers
      send(8'h3C, 1'b0, 1'b0);
      bitp(1'b0, 40);
      expect_rx("break", 8'h3C, 1'b0, 1'b1);
      chk("break_busy", 32'(o_busy), 32'(1));
      bitp(1'b1, 6);
      chk("break_idle", 32'(o_busy), 32'(0));
      bitp(1'b1, 40);
      chk("break_single", 32'(q.size()), 32'(0));

      bitp(1'b0, 4);
      bitp(1'b1, 10);
      chk("glitch_busy", 32'(o_busy), 32'(0));
      chk("glitch_novalid", 32'(q.size()), 32'(0));

      bitp(1'b0, 16);
      bitp(1'b0, 16);
      bitp(1'b1, 16);
      bitp(1'b0, 16);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_data", 32'(o_data), 32'(0));
      chk("midrst_valid", 32'(o_valid), 32'(0));
      chk("midrst_perr", 32'(o_parity_err), 32'(0));
      chk("midrst_ferr", 32'(o_framing_err), 32'(0));
      chk("midrst_busy", 32'(o_busy), 32'(0));
      reset = 1'b0;
      bitp(1'b1, 200);
      chk("midrst_novalid", 32'(q.size()), 32'(0));
      send(8'h5A, 1'b0, 1'b1);
      expect_rx("after_rst", 8'h5A, 1'b0, 1'b0);

      for (int i = 0; i < 200; i++) begin
         d = 8'($urandom);
         send(d, ^d, 1'b1);
         expect_rx($sformatf("loop%0d", i), d, 1'b0, 1'b0);
      end
      bitp(1'b1, 40);
      chk("loop_extra", 32'(q.size()), 32'(0));
      chk("loop_busy", 32'(o_busy), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
